// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: passive checker that decodes the active-low LED bus, tracks the
//   Red->Blue->Green phase order, times each phase in seconds and flags sequence/timing/pattern errors.
// Latency: phase follows led_in by 2 cycles (4 with LED_SYNC_EN defined); done/err update with phase.
// Backpressure: none; observe-only, every cycle is consumed.
module traffic_light_monitor #(
  parameter int CLK_PER_SEC = 24_000_000,
  parameter int RED_SECS    = 10,
  parameter int BLUE_SECS   = 3,
  parameter int GREEN_SECS  = 5,
  parameter int TOL_SECS    = 1,
  parameter int SEC_W       = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [2:0]       led_in,
  input  logic             clr_err,
  output logic [1:0]       phase,
  output logic             done_stb,
  output logic [1:0]       done_phase,
  output logic [SEC_W-1:0] done_secs,
  output logic             err_seq,
  output logic             err_time,
  output logic             err_pattern,
  output logic [7:0]       err_cnt
);

  localparam int CYC_W = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CLK_PER_SEC - 1);
  localparam logic [SEC_W-1:0] SEC_MAX  = {SEC_W{1'b1}};

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    RED      = 2'd1,
    BLUE     = 2'd2,
    GREEN    = 2'd3
  } state_t;

  // Active-low LED codes map straight onto phases; anything else is illegal.
  function automatic state_t decode(input logic [2:0] code);
    case (code)
      3'b101:  decode = RED;
      3'b011:  decode = BLUE;
      3'b110:  decode = GREEN;
      default: decode = UNLOCKED;
    endcase
  endfunction

  function automatic state_t next_legal(input state_t s);
    case (s)
      RED:     next_legal = BLUE;
      BLUE:    next_legal = GREEN;
      GREEN:   next_legal = RED;
      default: next_legal = UNLOCKED;
    endcase
  endfunction

  function automatic int exp_secs(input state_t s);
    case (s)
      RED:     exp_secs = RED_SECS;
      BLUE:    exp_secs = BLUE_SECS;
      GREEN:   exp_secs = GREEN_SECS;
      default: exp_secs = 0;
    endcase
  endfunction

  logic [2:0] led_src;
  logic [2:0] led_q, led_d;

`ifdef LED_SYNC_EN
  logic [2:0] sync1_q, sync1_d;
  logic [2:0] sync2_q, sync2_d;

  // Two-flop synchronizer for LED signals arriving from another domain.
  always_comb begin
    sync1_d = led_in;
    sync2_d = sync1_q;
  end

  // Synchronizer registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_q <= 3'b000;
      sync2_q <= 3'b000;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign led_src = sync2_q;
`else
  assign led_src = led_in;
`endif

  state_t           state_q, state_d;
  logic             first_q, first_d;
  logic             stuck_q, stuck_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [SEC_W-1:0] sec_q, sec_d;
  logic             done_stb_q, done_stb_d;
  logic [1:0]       done_phase_q, done_phase_d;
  logic [SEC_W-1:0] done_secs_q, done_secs_d;
  logic             err_seq_q, err_seq_d;
  logic             err_time_q, err_time_d;
  logic             err_pat_q, err_pat_d;
  logic [7:0]       err_cnt_q, err_cnt_d;

  state_t           dec;
  logic [CYC_W-1:0] cyc_adv;
  logic [SEC_W-1:0] sec_adv;
  logic             evt_seq, evt_time, evt_pat, evt_any;
  int               diff;

  // Phase FSM, second timer and per-phase checks; sec_adv includes the current cycle.
  always_comb begin
    led_d        = led_src;
    dec          = decode(led_q);
    state_d      = state_q;
    first_d      = first_q;
    stuck_d      = stuck_q;
    done_stb_d   = 1'b0;
    done_phase_d = done_phase_q;
    done_secs_d  = done_secs_q;
    evt_seq      = 1'b0;
    evt_time     = 1'b0;
    evt_pat      = 1'b0;
    diff         = 0;

    if (cyc_q == CYC_LAST) begin
      cyc_adv = '0;
      sec_adv = (sec_q == SEC_MAX) ? sec_q : sec_q + 1'b1;
    end else begin
      cyc_adv = cyc_q + 1'b1;
      sec_adv = sec_q;
    end
    cyc_d = cyc_adv;
    sec_d = sec_adv;

    if (state_q == UNLOCKED) begin
      cyc_d   = '0;
      sec_d   = '0;
      stuck_d = 1'b0;
      if (dec != UNLOCKED) begin
        // Locking mid-phase: this first phase is partial and is not timed.
        state_d = dec;
        first_d = 1'b1;
      end
    end else if (dec == UNLOCKED) begin
      state_d = UNLOCKED;
      first_d = 1'b0;
      stuck_d = 1'b0;
      cyc_d   = '0;
      sec_d   = '0;
      evt_pat = 1'b1;
    end else if (dec != state_q) begin
      state_d = dec;
      first_d = 1'b0;
      stuck_d = 1'b0;
      cyc_d   = '0;
      sec_d   = '0;
      evt_seq = (dec != next_legal(state_q));
      if (!first_q) begin
        done_stb_d   = 1'b1;
        done_phase_d = state_q;
        done_secs_d  = sec_adv;
        diff         = int'(sec_adv) - exp_secs(state_q);
        // A phase already flagged as stuck is not flagged again at its end.
        evt_time     = !stuck_q && ((diff > TOL_SECS) || (diff < -TOL_SECS));
      end
    end else if (!stuck_q && (int'(sec_adv) >= exp_secs(state_q) + TOL_SECS + 1)) begin
      evt_time = 1'b1;
      stuck_d  = 1'b1;
    end
  end

  // Sticky error flags and saturating event counter; a same-cycle event beats clr_err.
  always_comb begin
    evt_any = evt_seq | evt_time | evt_pat;
    if (clr_err) begin
      err_seq_d  = evt_seq;
      err_time_d = evt_time;
      err_pat_d  = evt_pat;
      err_cnt_d  = evt_any ? 8'd1 : 8'd0;
    end else begin
      err_seq_d  = err_seq_q | evt_seq;
      err_time_d = err_time_q | evt_time;
      err_pat_d  = err_pat_q | evt_pat;
      err_cnt_d  = (evt_any && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
    end
  end

  // State, timer, result and error registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      led_q        <= 3'b000;
      state_q      <= UNLOCKED;
      first_q      <= 1'b0;
      stuck_q      <= 1'b0;
      cyc_q        <= '0;
      sec_q        <= '0;
      done_stb_q   <= 1'b0;
      done_phase_q <= 2'd0;
      done_secs_q  <= '0;
      err_seq_q    <= 1'b0;
      err_time_q   <= 1'b0;
      err_pat_q    <= 1'b0;
      err_cnt_q    <= 8'd0;
    end else begin
      led_q        <= led_d;
      state_q      <= state_d;
      first_q      <= first_d;
      stuck_q      <= stuck_d;
      cyc_q        <= cyc_d;
      sec_q        <= sec_d;
      done_stb_q   <= done_stb_d;
      done_phase_q <= done_phase_d;
      done_secs_q  <= done_secs_d;
      err_seq_q    <= err_seq_d;
      err_time_q   <= err_time_d;
      err_pat_q    <= err_pat_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign phase       = state_q;
  assign done_stb    = done_stb_q;
  assign done_phase  = done_phase_q;
  assign done_secs   = done_secs_q;
  assign err_seq     = err_seq_q;
  assign err_time    = err_time_q;
  assign err_pattern = err_pat_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb_traffic_light_monitor: directed vector table plus hand sequences for traffic_light_monitor.
// Latency: expects phase/strobe 2 cycles after an led_in change (CLK_PER_SEC=4).
// Backpressure: none; inputs driven 1 time unit after each rising edge, outputs sampled there too.
module tb_traffic_light_monitor;

  logic       sys_clk;
  logic       sys_rst_n;
  logic [2:0] led_in;
  logic       clr_err;
  logic [1:0] phase;
  logic       done_stb;
  logic [1:0] done_phase;
  logic [7:0] done_secs;
  logic       err_seq;
  logic       err_time;
  logic       err_pattern;
  logic [7:0] err_cnt;

  int passed = 0;
  int total  = 0;

  traffic_light_monitor #(
    .CLK_PER_SEC(4),
    .RED_SECS(10),
    .BLUE_SECS(3),
    .GREEN_SECS(5),
    .TOL_SECS(1),
    .SEC_W(8)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst_n(sys_rst_n),
    .led_in(led_in),
    .clr_err(clr_err),
    .phase(phase),
    .done_stb(done_stb),
    .done_phase(done_phase),
    .done_secs(done_secs),
    .err_seq(err_seq),
    .err_time(err_time),
    .err_pattern(err_pattern),
    .err_cnt(err_cnt)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [2:0] led;
    int         hold;
    logic [1:0] ph;
    logic       stb;
    logic [1:0] dph;
    int         dsecs;
    logic [2:0] err;   // {seq, time, pattern}
    int         cnt;
  } vec_t;

  vec_t vecs[$];

  localparam logic [2:0] R = 3'b101;
  localparam logic [2:0] B = 3'b011;
  localparam logic [2:0] G = 3'b110;
  localparam logic [2:0] X = 3'b000;

  task automatic step(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic chk_state(input string tag, input int ph, input int errs, input int cnt);
    chk({tag, " phase"}, int'(phase), ph);
    chk({tag, " err{seq,time,pat}"}, int'({err_seq, err_time, err_pattern}), errs);
    chk({tag, " err_cnt"}, int'(err_cnt), cnt);
  endtask

  task automatic chk_stb(input string tag, input int dph, input int dsecs);
    chk({tag, " done_stb"}, int'(done_stb), 1);
    chk({tag, " done_phase"}, int'(done_phase), dph);
    chk({tag, " done_secs"}, int'(done_secs), dsecs);
  endtask

  initial begin
    sys_rst_n = 1'b0;
    led_in    = X;
    clr_err   = 1'b0;

    //            led hold ph stb dph secs err     cnt
    vecs.push_back('{R,  8, 1, 0, 0,  0, 3'b000, 0});  // lock on Red, partial
    vecs.push_back('{B, 12, 2, 0, 0,  0, 3'b000, 0});  // no strobe for partial Red
    vecs.push_back('{G, 20, 3, 1, 2,  3, 3'b000, 0});
    vecs.push_back('{R, 40, 1, 1, 3,  5, 3'b000, 0});
    vecs.push_back('{B,  4, 2, 1, 1, 10, 3'b000, 0});
    vecs.push_back('{G, 20, 3, 1, 2,  1, 3'b010, 1});  // short Blue
    vecs.push_back('{R, 40, 1, 1, 3,  5, 3'b010, 1});
    vecs.push_back('{G, 20, 3, 1, 1, 10, 3'b110, 2});  // Red -> Green out of order
    vecs.push_back('{X, 10, 0, 0, 0,  0, 3'b111, 3});  // illegal code
    vecs.push_back('{R,  8, 1, 0, 0,  0, 3'b111, 3});  // relock, partial
    vecs.push_back('{B, 12, 2, 0, 0,  0, 3'b111, 3});  // no strobe at relocked Red end

    // Reset held with led_in toggling: everything stays cleared.
    for (int i = 0; i < 4; i++) begin
      led_in = (i % 2 == 0) ? R : B;
      step(1);
      chk("reset done_stb", int'(done_stb), 0);
      chk_state("reset", 0, 0, 0);
    end
    led_in    = R;
    sys_rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      led_in = vecs[i].led;
      step(2);
      chk_state($sformatf("vec%0d", i), int'(vecs[i].ph), int'(vecs[i].err), vecs[i].cnt);
      if (vecs[i].stb) chk_stb($sformatf("vec%0d", i), int'(vecs[i].dph), vecs[i].dsecs);
      else chk($sformatf("vec%0d done_stb", i), int'(done_stb), 0);
      step(1);
      chk($sformatf("vec%0d stb pulse width", i), int'(done_stb), 0);
      if (vecs[i].hold > 3) step(vecs[i].hold - 3);
    end

    // clr_err while Blue holds (Blue now 13 cycles = 3 s).
    clr_err = 1'b1;
    step(1);
    clr_err = 1'b0;
    chk_state("clr", 2, 0, 0);

    // Stuck Green: err_time fires 28 cycles after entry, once.
    led_in = G;
    step(2);
    chk_stb("stuck entry", 2, 3);
    chk_state("stuck entry", 3, 0, 0);
    step(27);
    chk_state("stuck before", 3, 0, 0);
    step(1);
    chk_state("stuck fire", 3, 3'b010, 1);
    step(10);
    led_in = R;
    step(2);
    chk_stb("stuck end", 3, 10);
    chk_state("stuck end", 1, 3'b010, 1);

    // clr_err in the same cycle as a new err_seq event: the event wins.
    step(38);
    led_in = G;
    step(1);
    clr_err = 1'b1;
    step(1);
    clr_err = 1'b0;
    chk_stb("clr+seq", 1, 10);
    chk_state("clr+seq", 3, 3'b100, 1);

    // Drive enough illegal-code events to saturate err_cnt.
    for (int i = 0; i < 260; i++) begin
      led_in = R;
      step(2);
      led_in = X;
      step(2);
    end
    chk("sat err_cnt", int'(err_cnt), 255);
    chk("sat err_pattern", int'(err_pattern), 1);
    chk("sat phase", int'(phase), 0);

    // Reset mid-phase discards everything; relock as from power-up.
    led_in = R;
    step(4);
    sys_rst_n = 1'b0;
    step(1);
    chk_state("mid reset", 0, 0, 0);
    sys_rst_n = 1'b1;
    step(2);
    chk_state("relock", 1, 0, 0);
    chk("relock done_stb", int'(done_stb), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/traffic_light_monitor.md
Name: traffic_light_monitor

Overview:
Passive checker on the traffic-light LED bus. It decodes the 3-bit active-low LED code, tracks the phase sequence Red -> Blue -> Green -> Red, and measures each phase in whole seconds. It reports phase-complete events and flags sequence, timing and illegal-pattern errors. It sits beside the light controller on the same sys_clk and observes the controller's led output without driving anything back.

Parameters:
CLK_PER_SEC, 24_000_000, sys_clk cycles per second tick
RED_SECS, 10, expected Red duration in seconds
BLUE_SECS, 3, expected Blue duration in seconds
GREEN_SECS, 5, expected Green duration in seconds
TOL_SECS, 1, allowed absolute deviation from expected duration, in seconds
SEC_W, 8, width of the seconds counter and done_secs

Ports:
sys_clk  in  1  clock
sys_rst_n  in  1  reset
led_in  in  3  observed LED code: 3'b101 Red, 3'b011 Blue, 3'b110 Green, anything else illegal
clr_err  in  1  synchronous clear of sticky errors and err_cnt
phase  out  2  current phase: 0 unlocked, 1 Red, 2 Blue, 3 Green
done_stb  out  1  one-cycle pulse when a measured phase ends
done_phase  out  2  phase that just ended; valid with done_stb
done_secs  out  SEC_W  measured duration of the ended phase; valid with done_stb
err_seq  out  1  sticky: illegal phase order seen
err_time  out  1  sticky: phase duration outside tolerance
err_pattern  out  1  sticky: illegal LED code seen
err_cnt  out  8  count of error events, saturating at 255

Behaviour:
- Reset: sys_rst_n is asynchronous and active-low; sys_clk is the clock. Reset clears all outputs and counters to 0: phase=0 and all done and error outputs 0.
- led_in is registered once before decode. phase updates on the clock edge after the registered code changes, i.e. 2 cycles after the led_in change.
- States: UNLOCKED, RED, BLUE, GREEN.
- Timing counters: cyc_cnt counts 0..CLK_PER_SEC-1; at the terminal count it wraps to 0 and sec_cnt increments, saturating at 2^SEC_W-1. Both counters clear on every phase entry.
- Leaving UNLOCKED: the first legal code enters its phase with first_flag=1. That phase is partial, so no done_stb and no time check at its end.
- Legal transitions: RED->BLUE, BLUE->GREEN, GREEN->RED.
- On any legal-code change from a locked state:
  - done_stb=1 for one cycle, done_phase=old phase, done_secs=sec_cnt.
  - This applies unless first_flag=1, in which case there is no strobe and first_flag clears.
  - If the strobe fires, the time check is |done_secs - expected| <= TOL_SECS; on failure set err_time.
  - An out-of-order transition (e.g. RED->GREEN) sets err_seq. The monitor still enters the new phase with first_flag=0; the measurement is valid from an edge.
- Stuck phase: if sec_cnt reaches expected+TOL_SECS+1 while in the phase, set err_time immediately, once per phase. The later end-of-phase check for that phase does not flag again.
- Illegal code: set err_pattern and go to UNLOCKED with phase=0. No done_stb. Holding the illegal code does not re-flag.
- err_cnt increments by 1 per cycle containing at least one new error event, even if several occur together, and saturates at 255.
- clr_err clears err_seq, err_time, err_pattern and err_cnt. If an error event occurs in the same cycle, the event wins: the flag is set and err_cnt=1.
- A reset mid-phase discards the measurement; the monitor relocks as from power-up.

Optional Feature:
LED_SYNC_EN: when defined, led_in first passes through a 2-flop synchronizer, for LED signals from a different clock domain or pins. Input-to-phase latency becomes 4 cycles. When undefined, only the single input register is present and latency is 2 cycles. All other behaviour is identical.

Test Plan:
All scenarios use CLK_PER_SEC=4 and default durations.
1. Reset: hold sys_rst_n=0 with led_in toggling -> phase=0, done_stb=0, all err=0, err_cnt=0; release with led_in=101 -> phase=1 two cycles later.
2. Lock on Red, then Blue 12 cycles, Green 20 cycles, Red 40 cycles, then Blue -> done_stb with (phase 2, secs 3), (3, 5), (1, 10); no strobe for the first Red; no errors.
3. Locked Blue held 4 cycles (1 s) then Green -> done_secs=1, err_time=1, err_cnt=1, phase=3.
4. Red then directly Green -> err_seq=1, done_phase=1, err_cnt increments, phase=3.
5. led_in=3'b000 for 10 cycles then 101 -> err_pattern=1, phase=0 during the illegal code, err_cnt +1 only once; relock to Red with no strobe at that Red's end.
6. Green held 40 cycles -> err_time set when sec_cnt=7 (28 cycles after entry); end strobe reports done_secs=10 with no additional err_cnt; clr_err pulsed in the cycle of a new err_seq event -> err_seq=1, err_cnt=1.
